// File: rtl/pe_result_store_pkg.sv
// Shared constants, types and helpers for the PE result write-back path.
package pe_result_store_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LANE_N     = 4;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned DIMEN_W    = 2;
    localparam int unsigned WE_W       = 4;

    // Full-word byte write enable for BRAM port B
    localparam logic [WE_W-1:0] WE_ALL = 4'hF;

    // Store engine states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WAIT_BEAT = 2'd1;
    localparam state_t ST_WRITE     = 2'd2;
    localparam state_t ST_DONE      = 2'd3;

    // Four PE result lanes, lane 0 in the low word
    typedef logic [LANE_N-1:0][DATA_W-1:0] lane_vec_t;

    // A captured result beat: remaining lane mask plus lane data
    typedef struct packed {
        logic [LANE_N-1:0] mask;
        lane_vec_t         data;
    } beat_t;

    // DIMEN code to transaction word count; shared with the fetch unit
    function automatic logic [CNT_W-1:0] dimen_to_words(input logic [DIMEN_W-1:0] dimen);
        logic [CNT_W-1:0] words;
        case (dimen)
            2'd0:    words = 5'd2;
            2'd1:    words = 5'd4;
            2'd2:    words = 5'd8;
            default: words = 5'd16;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/pe_result_store_lane_select.sv
// Lowest-set-bit priority encoder over the remaining lane mask.
module pe_lane_select
    import pe_result_store_pkg::*;
(
    input  logic [LANE_N-1:0]     mask,
    output logic [LANE_IDX_W-1:0] lane_idx_c,
    output logic [LANE_N-1:0]     clear_c
);

    // Scan from the top so the lowest set bit wins
    always_comb begin
        lane_idx_c = '0;
        clear_c    = '0;
        for (int i = LANE_N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lane_idx_c = LANE_IDX_W'(i);
                clear_c    = LANE_N'(1) << i;
            end
        end
    end

endmodule

// File: rtl/pe_result_store.sv
// Drains masked PE result beats into BRAM port B, one word per cycle,
// at consecutive addresses from a latched base until N words are written.
module pe_result_store
    import pe_result_store_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  STORE_START,
    input  logic [ADDR_W-1:0]     BASE_ADDR,
    input  logic [DIMEN_W-1:0]    DIMEN,
    input  logic                  RES_VALID,
    output logic                  RES_READY,
    input  logic [LANE_N-1:0]     RES_MASK,
    input  logic [DATA_W-1:0]     PE_DOUT_0,
    input  logic [DATA_W-1:0]     PE_DOUT_1,
    input  logic [DATA_W-1:0]     PE_DOUT_2,
    input  logic [DATA_W-1:0]     PE_DOUT_3,
    output logic [ADDR_W-1:0]     addrb,
    output logic [DATA_W-1:0]     dinb,
    output logic                  enb,
    output logic [WE_W-1:0]       web,
    output logic                  BUSY,
    output logic                  STORE_DONE,
    output logic [CNT_W-1:0]      WORD_CNT
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   base_nxt;
    logic [CNT_W-1:0]    words_q;
    logic [CNT_W-1:0]    words_nxt;
    beat_t               beat_q;
    beat_t               beat_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    logic [ADDR_W-1:0]   addrb_nxt;
    logic [DATA_W-1:0]   dinb_nxt;
    logic                enb_nxt;
    logic [WE_W-1:0]     web_nxt;
    logic                ready_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    lane_vec_t           pe_lanes;
    lane_vec_t           lane_src;
    logic [LANE_N-1:0]   sel_mask;
    logic [LANE_IDX_W-1:0] sel_idx;
    logic [LANE_N-1:0]   sel_clear;
    logic                do_write;

    assign pe_lanes = {PE_DOUT_3, PE_DOUT_2, PE_DOUT_1, PE_DOUT_0};

    // First write of a beat launches at the acceptance edge from the live
    // inputs; later writes come from the captured copy.
    assign lane_src = (state == ST_WAIT_BEAT) ? pe_lanes : beat_q.data;
    assign sel_mask = (state == ST_WAIT_BEAT) ? RES_MASK : beat_q.mask;

    pe_lane_select u_lane_select (
        .mask       (sel_mask),
        .lane_idx_c (sel_idx),
        .clear_c    (sel_clear)
    );

    // Next-state and next-output decode
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        words_nxt = words_q;
        beat_nxt  = beat_q;
        cnt_nxt   = WORD_CNT;
        addrb_nxt = addrb;
        dinb_nxt  = dinb;
        enb_nxt   = 1'b0;
        web_nxt   = '0;
        do_write  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (STORE_START) begin
                    base_nxt  = BASE_ADDR;
                    words_nxt = dimen_to_words(DIMEN);
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT_BEAT;
                end
            end
            ST_WAIT_BEAT: begin
                // Zero-mask beats are consumed without leaving this state
                if (RES_VALID && RES_READY && (RES_MASK != '0)) begin
                    beat_nxt.data = pe_lanes;
                    do_write      = 1'b1;
                    state_nxt     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Count reached: leftover lanes of this beat are dropped
                if (WORD_CNT == words_q) begin
                    state_nxt = ST_DONE;
                end else if (beat_q.mask == '0) begin
                    state_nxt = ST_WAIT_BEAT;
                end else begin
                    do_write = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (do_write) begin
            addrb_nxt     = base_q + ADDR_W'(WORD_CNT);
            dinb_nxt      = lane_src[sel_idx];
            enb_nxt       = 1'b1;
            web_nxt       = WE_ALL;
            cnt_nxt       = WORD_CNT + CNT_W'(1);
            beat_nxt.mask = sel_mask & ~sel_clear;
        end

        ready_nxt = (state_nxt == ST_WAIT_BEAT);
        busy_nxt  = (state_nxt != ST_IDLE);
        done_nxt  = (state_nxt == ST_DONE);
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            words_q    <= '0;
            beat_q     <= '0;
            WORD_CNT   <= '0;
            addrb      <= '0;
            dinb       <= '0;
            enb        <= 1'b0;
            web        <= '0;
            RES_READY  <= 1'b0;
            BUSY       <= 1'b0;
            STORE_DONE <= 1'b0;
        end else begin
            state      <= state_nxt;
            base_q     <= base_nxt;
            words_q    <= words_nxt;
            beat_q     <= beat_nxt;
            WORD_CNT   <= cnt_nxt;
            addrb      <= addrb_nxt;
            dinb       <= dinb_nxt;
            enb        <= enb_nxt;
            web        <= web_nxt;
            RES_READY  <= ready_nxt;
            BUSY       <= busy_nxt;
            STORE_DONE <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pe_result_store.sv
// Directed bench for pe_result_store: write log collected on the falling
// edge, expected addresses/data written out by hand per scenario.
module tb_pe_result_store;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STORE_START;
    logic [31:0] BASE_ADDR;
    logic [1:0]  DIMEN;
    logic        RES_VALID;
    logic        RES_READY;
    logic [3:0]  RES_MASK;
    logic [31:0] PE_DOUT_0, PE_DOUT_1, PE_DOUT_2, PE_DOUT_3;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic        enb;
    logic [3:0]  web;
    logic        BUSY;
    logic        STORE_DONE;
    logic [4:0]  WORD_CNT;

    int vectors     = 0;
    int miscompares = 0;

    int          cyc = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          bad_web  = 0;

    pe_result_store dut (
        .CLK         (CLK),
        .RST         (RST),
        .STORE_START (STORE_START),
        .BASE_ADDR   (BASE_ADDR),
        .DIMEN       (DIMEN),
        .RES_VALID   (RES_VALID),
        .RES_READY   (RES_READY),
        .RES_MASK    (RES_MASK),
        .PE_DOUT_0   (PE_DOUT_0),
        .PE_DOUT_1   (PE_DOUT_1),
        .PE_DOUT_2   (PE_DOUT_2),
        .PE_DOUT_3   (PE_DOUT_3),
        .addrb       (addrb),
        .dinb        (dinb),
        .enb         (enb),
        .web         (web),
        .BUSY        (BUSY),
        .STORE_DONE  (STORE_DONE),
        .WORD_CNT    (WORD_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // BRAM write log and completion pulse log
    always @(negedge CLK) begin
        if (enb === 1'b1) begin
            wr_addr_q.push_back(addrb);
            wr_data_q.push_back(dinb);
            wr_cyc_q.push_back(cyc);
            if (web !== 4'hF) bad_web++;
        end
        if (STORE_DONE === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wr_addr_q.size()) begin
            chk($sformatf("wr%0d_addr", idx), wr_addr_q[idx], a);
            chk($sformatf("wr%0d_data", idx), wr_data_q[idx], d);
        end else begin
            chk($sformatf("wr%0d_present", idx), 32'(wr_addr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic start(input logic [31:0] base, input logic [1:0] dimen);
        STORE_START = 1'b1;
        BASE_ADDR   = base;
        DIMEN       = dimen;
        tick();
        STORE_START = 1'b0;
        BASE_ADDR   = 32'hDEAD_0000;
        DIMEN       = 2'd3;
    endtask

    // Present one beat, wait (bounded) for acceptance, then scramble inputs
    task automatic beat(input logic [3:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
        RES_VALID = 1'b1;
        RES_MASK  = mask;
        PE_DOUT_0 = d0;
        PE_DOUT_1 = d1;
        PE_DOUT_2 = d2;
        PE_DOUT_3 = d3;
        for (int i = 0; i < 20 && RES_READY !== 1'b1; i++) tick();
        chk("beat_ready", 32'(RES_READY), 32'd1);
        tick();
        RES_VALID = 1'b0;
        RES_MASK  = 4'hF;
        PE_DOUT_0 = 32'hBAD0_0000;
        PE_DOUT_1 = 32'hBAD0_0001;
        PE_DOUT_2 = 32'hBAD0_0002;
        PE_DOUT_3 = 32'hBAD0_0003;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && STORE_DONE !== 1'b1; i++) tick();
        chk("done_seen", 32'(STORE_DONE), 32'd1);
    endtask

    initial begin
        int done_before;

        RST         = 1'b1;
        STORE_START = 1'b0;
        BASE_ADDR   = '0;
        DIMEN       = '0;
        RES_VALID   = 1'b0;
        RES_MASK    = '0;
        PE_DOUT_0   = '0;
        PE_DOUT_1   = '0;
        PE_DOUT_2   = '0;
        PE_DOUT_3   = '0;

        // Reset state
        tick();
        tick();
        RST = 1'b0;
        chk("rst_addrb", addrb, 32'h0);
        chk("rst_dinb", dinb, 32'h0);
        chk("rst_enb", 32'(enb), 32'd0);
        chk("rst_web", 32'(web), 32'd0);
        chk("rst_ready", 32'(RES_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(STORE_DONE), 32'd0);
        chk("rst_wcnt", 32'(WORD_CNT), 32'd0);
        tick();
        chk("idle_ready", 32'(RES_READY), 32'd0);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_nowrite", 32'(wr_addr_q.size()), 32'd0);

        // Full beat, N=4
        clear_log();
        start(32'h100, 2'd1);
        chk("full_busy", 32'(BUSY), 32'd1);
        chk("full_ready", 32'(RES_READY), 32'd1);
        chk("full_wcnt0", 32'(WORD_CNT), 32'd0);
        beat(4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        chk("full_first_enb", 32'(enb), 32'd1);
        chk("full_first_addr", addrb, 32'h100);
        chk("full_first_data", dinb, 32'hA0);
        chk("full_first_web", 32'(web), 32'hF);
        chk("full_ready_low", 32'(RES_READY), 32'd0);
        wait_done();
        chk("full_done_wcnt", 32'(WORD_CNT), 32'd4);
        chk("full_done_busy", 32'(BUSY), 32'd1);
        chk("full_done_enb", 32'(enb), 32'd0);
        tick();
        chk("full_after_busy", 32'(BUSY), 32'd0);
        chk("full_after_done", 32'(STORE_DONE), 32'd0);
        chk("full_wr_count", 32'(wr_addr_q.size()), 32'd4);
        chk_wr(0, 32'h100, 32'hA0);
        chk_wr(1, 32'h101, 32'hA1);
        chk_wr(2, 32'h102, 32'hA2);
        chk_wr(3, 32'h103, 32'hA3);
        if (wr_cyc_q.size() == 4) begin
            chk("full_consecutive", 32'(wr_cyc_q[3] - wr_cyc_q[0]), 32'd3);
            chk("full_done_latency", 32'(done_cyc - wr_cyc_q[3]), 32'd1);
        end else begin
            chk("full_cyc_log", 32'(wr_cyc_q.size()), 32'd4);
        end

        // Empty then sparse mask, N=2
        clear_log();
        start(32'h200, 2'd0);
        beat(4'b0000, 32'h1, 32'h2, 32'h3, 32'h4);
        chk("empty_nowrite", 32'(enb), 32'd0);
        chk("empty_ready", 32'(RES_READY), 32'd1);
        chk("empty_wcnt", 32'(WORD_CNT), 32'd0);
        done_before = done_cnt;
        beat(4'b1010, 32'hDEAD, 32'h11, 32'hBEEF, 32'h33);
        wait_done();
        chk("sparse_wcnt", 32'(WORD_CNT), 32'd2);
        tick();
        chk("sparse_wr_count", 32'(wr_addr_q.size()), 32'd2);
        chk_wr(0, 32'h200, 32'h11);
        chk_wr(1, 32'h201, 32'h33);
        chk("sparse_done_once", 32'(done_cnt - done_before), 32'd1);

        // Overflow drop, N=2 with four lanes
        clear_log();
        start(32'h300, 2'd0);
        beat(4'hF, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        wait_done();
        chk("ovf_wcnt", 32'(WORD_CNT), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        chk("ovf_wr_count", 32'(wr_addr_q.size()), 32'd2);
        chk_wr(0, 32'h300, 32'hB0);
        chk_wr(1, 32'h301, 32'hB1);
        chk("ovf_wcnt_hold", 32'(WORD_CNT), 32'd2);

        // Handshake stall with ignored mid-transaction start, N=4
        clear_log();
        start(32'h400, 2'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                STORE_START = 1'b1;
                BASE_ADDR   = 32'h999;
                DIMEN       = 2'd0;
            end
            tick();
            STORE_START = 1'b0;
            chk($sformatf("stall%0d_ready", i), 32'(RES_READY), 32'd1);
            chk($sformatf("stall%0d_busy", i), 32'(BUSY), 32'd1);
            chk($sformatf("stall%0d_enb", i), 32'(enb), 32'd0);
        end
        done_before = done_cnt;
        beat(4'b0011, 32'hC0, 32'hC1, 32'hCC, 32'hCD);
        tick();
        tick();
        chk("stall_rewait_ready", 32'(RES_READY), 32'd1);
        chk("stall_rewait_busy", 32'(BUSY), 32'd1);
        chk("stall_no_early_done", 32'(done_cnt - done_before), 32'd0);
        beat(4'b1100, 32'hEE, 32'hEF, 32'hC2, 32'hC3);
        wait_done();
        chk("stall_wcnt", 32'(WORD_CNT), 32'd4);
        STORE_START = 1'b1;
        BASE_ADDR   = 32'h777;
        DIMEN       = 2'd1;
        tick();
        STORE_START = 1'b0;
        chk("done_start_busy", 32'(BUSY), 32'd0);
        chk("done_start_ready", 32'(RES_READY), 32'd0);
        tick();
        chk("done_start_idle", 32'(BUSY), 32'd0);
        chk("stall_wr_count", 32'(wr_addr_q.size()), 32'd4);
        chk_wr(0, 32'h400, 32'hC0);
        chk_wr(1, 32'h401, 32'hC1);
        chk_wr(2, 32'h402, 32'hC2);
        chk_wr(3, 32'h403, 32'hC3);

        // Abort after two of eight writes
        clear_log();
        start(32'h500, 2'd2);
        beat(4'hF, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        tick();
        chk("abort_second_addr", addrb, 32'h501);
        done_before = done_cnt;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_enb", 32'(enb), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_wcnt", 32'(WORD_CNT), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_wr_count", 32'(wr_addr_q.size()), 32'd2);
        chk("abort_no_done", 32'(done_cnt - done_before), 32'd0);

        // Restart after abort, base at the top of the address space
        clear_log();
        start(32'hFFFF_FFFF, 2'd0);
        chk("restart_wcnt", 32'(WORD_CNT), 32'd0);
        chk("restart_busy", 32'(BUSY), 32'd1);
        beat(4'b0001, 32'hE0, 32'h0, 32'h0, 32'h0);
        beat(4'b0001, 32'hE1, 32'h0, 32'h0, 32'h0);
        wait_done();
        chk("restart_final_wcnt", 32'(WORD_CNT), 32'd2);
        tick();
        chk("restart_wr_count", 32'(wr_addr_q.size()), 32'd2);
        chk_wr(0, 32'hFFFF_FFFF, 32'hE0);
        chk_wr(1, 32'h0000_0000, 32'hE1);

        chk("web_on_writes", 32'(bad_web), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
